// File: rtl/lc3_regfile_sb_if.sv
// Bus between decode/writeback and the LC-3 register file with busy scoreboard.
// The master side issues, writes back and reads; the slave side is the register file.
interface lc3_regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
);
  localparam int NREGS = 2 ** ADDR_W;

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       iss_en;
  logic [ADDR_W-1:0]          iss_addr;
  logic                       iss_ready;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [NREGS-1:0]           busy_vec;
  logic                       iss_err;

  modport master (
    output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr,
    input  iss_ready, rd_data, rd_busy, busy_vec, iss_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr,
    output iss_ready, rd_data, rd_busy, busy_vec, iss_err
  );
endinterface

// File: rtl/lc3_regfile_sb.sv
// Parametrised LC-3 register file with per-register busy scoreboard and combinational reads.
// Define LC3_REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module lc3_regfile_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input  logic               clk,
  input  logic               reset,
  lc3_regfile_sb_if.slave    bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic              iss_err_q;
  logic              iss_err_d;
  logic              iss_ready;

  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  // Issue check always looks at the registered busy bit, never at forwarding.
  assign iss_ready = ~busy_q[bus.iss_addr];

  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    iss_err_d = iss_err_q;
    if (bus.wr_en) begin
      regs_d[bus.wr_addr] = bus.wr_data;
      busy_d[bus.wr_addr] = 1'b0;
    end
    // Evaluated after the writeback clear so an accepted issue to the same register wins.
    if (bus.iss_en) begin
      if (iss_ready) begin
        busy_d[bus.iss_addr] = 1'b1;
      end else begin
        iss_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      iss_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q    <= busy_d;
      iss_err_q <= iss_err_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_c[k*DATA_W +: DATA_W] = regs_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
      rd_busy_c[k]                  = busy_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef LC3_REGFILE_BYPASS_EN
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
        rd_busy_c[k]                  = 1'b0;
      end
`endif
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.rd_busy   = rd_busy_c;
  assign bus.busy_vec  = busy_q;
  assign bus.iss_err   = iss_err_q;
  assign bus.iss_ready = iss_ready;
endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Directed and randomized bench for lc3_regfile_sb against an array-based reference model.
module tb_lc3_regfile_sb;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NUM_RD = 2;
  localparam int NREGS  = 8;
`ifdef LC3_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lc3_regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  lc3_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  logic [15:0] m_regs [NREGS];
  bit          m_busy [NREGS];
  bit          m_err;

  // Current stimulus, kept in the bench for the model.
  bit          s_we, s_ie;
  int          s_wa, s_ia;
  logic [15:0] s_wd;
  int          s_ra [NUM_RD];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit we, input int wa, input logic [15:0] wd,
                       input bit ie, input int ia, input int r0, input int r1);
    logic [2:0] a0, a1;
    s_we = we; s_wa = wa; s_wd = wd; s_ie = ie; s_ia = ia;
    s_ra[0] = r0; s_ra[1] = r1;
    a0 = r0[2:0];
    a1 = r1[2:0];
    bus.wr_en    = we;
    bus.wr_addr  = wa[2:0];
    bus.wr_data  = wd;
    bus.iss_en   = ie;
    bus.iss_addr = ia[2:0];
    bus.rd_addr  = {a1, a0};
  endtask

  function automatic logic [7:0] model_busy_vec();
    logic [7:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Compare every combinational output with what the model predicts for the current inputs.
  task automatic check_comb();
    logic [15:0] ed;
    bit          eb;
    for (int k = 0; k < NUM_RD; k++) begin
      ed = m_regs[s_ra[k]];
      eb = m_busy[s_ra[k]];
      if (BYP && s_we && s_wa == s_ra[k]) begin
        ed = s_wd;
        eb = 1'b0;
      end
      check($sformatf("rd_data%0d", k), bus.rd_data[k*DATA_W +: DATA_W], ed);
      check($sformatf("rd_busy%0d", k), bus.rd_busy[k], eb);
    end
    check("iss_ready", bus.iss_ready, !m_busy[s_ia]);
    check("busy_vec", bus.busy_vec, model_busy_vec());
    check("iss_err", bus.iss_err, m_err);
  endtask

  // Called at a negedge with inputs driven: check, advance the model, cross one rising edge.
  task automatic step(input bit do_check);
    bit ready;
    #1;
    if (do_check) check_comb();
    ready = !m_busy[s_ia];
    if (s_we) begin
      m_regs[s_wa] = s_wd;
      m_busy[s_wa] = 1'b0;
    end
    if (s_ie) begin
      if (ready) m_busy[s_ia] = 1'b1;
      else       m_err = 1'b1;
    end
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
    drive(0, 0, 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    step(1'b0);
    reset = 1'b0;

    // Reset clears state
    drive(1, 3, 16'hBEEF, 0, 0, 3, 3);
    step(1'b1);
    reset = 1'b1;
    drive(0, 0, 16'h0, 0, 3, 3, 3);
    step(1'b1);
    reset = 1'b0;
    #1;
    check("rst_rd0", bus.rd_data[15:0], 16'h0000);
    check("rst_rd1", bus.rd_data[31:16], 16'h0000);
    check("rst_busy_vec", bus.busy_vec, 8'h00);
    check("rst_iss_err", bus.iss_err, 1'b0);
    check("rst_iss_ready", bus.iss_ready, 1'b1);
    check("rst_rd_busy", bus.rd_busy, 2'b00);

    // Write then read
    drive(1, 5, 16'h1234, 0, 0, 5, 5);
    step(1'b1);
    drive(0, 0, 16'h0, 0, 0, 5, 5);
    #1;
    check("wr_rd_p0", bus.rd_data[15:0], 16'h1234);
    check("wr_rd_p1", bus.rd_data[31:16], 16'h1234);
    for (int r = 0; r < NREGS; r++) begin
      if (r != 5) begin
        drive(0, 0, 16'h0, 0, 0, r, r);
        #1;
        check($sformatf("untouched_r%0d", r), bus.rd_data[15:0], 16'h0000);
      end
    end

    // Scoreboard round trip
    drive(0, 0, 16'h0, 1, 2, 2, 0);
    step(1'b1);
    drive(0, 0, 16'h0, 0, 2, 2, 0);
    #1;
    check("sb_rd_busy", bus.rd_busy, 2'b01);
    check("sb_iss_ready", bus.iss_ready, 1'b0);
    drive(1, 2, 16'h00FF, 0, 2, 2, 0);
    step(1'b1);
    drive(0, 0, 16'h0, 0, 2, 2, 0);
    #1;
    check("sb_clear", bus.busy_vec[2], 1'b0);
    check("sb_data", bus.rd_data[15:0], 16'h00FF);

    // Double issue
    drive(0, 0, 16'h0, 1, 7, 7, 7);
    step(1'b1);
    step(1'b1);
    drive(0, 0, 16'h0, 0, 0, 7, 0);
    #1;
    check("dbl_iss_err", bus.iss_err, 1'b1);
    check("dbl_busy_vec", bus.busy_vec, 8'h80);
    step(1'b1);
    check("dbl_iss_err_sticky", bus.iss_err, 1'b1);

    // Same-cycle issue and write
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    drive(1, 4, 16'hA5A5, 1, 4, 4, 4);
    step(1'b1);
    drive(0, 0, 16'h0, 0, 0, 4, 4);
    #1;
    check("same_data", bus.rd_data[15:0], 16'hA5A5);
    check("same_busy", bus.busy_vec[4], 1'b1);
    check("same_err", bus.iss_err, 1'b0);

    // Forwarding (or its absence): R1 holds 1111 and is busy before the 7777 writeback
    drive(1, 1, 16'h1111, 1, 1, 1, 1);
    step(1'b1);
    drive(1, 1, 16'h7777, 0, 0, 1, 1);
    #1;
    check("byp_data", bus.rd_data[15:0], BYP ? 16'h7777 : 16'h1111);
    check("byp_busy", bus.rd_busy[0], BYP ? 1'b0 : 1'b1);
    step(1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 7), 16'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      step(1'b1);
    end
    reset = 1'b0;
    drive(0, 0, 16'h0, 0, 0, 0, 1);
    #1;
    check_comb();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/lc3_regfile_sb.md
# lc3_regfile_sb

Parametrised register file for the pipelined LC-3 datapath, generalised in data width, register count and read-port count. It adds a per-register busy scoreboard: decode marks a destination pending at issue, writeback clears it, and every read port reports whether its operand is still in flight. It sits between decode (issue, source reads) and writeback (register write).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports (1..4)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination register
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  issue strobe; marks iss_addr busy
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- iss_ready  out  1  combinational; 1 when busy[iss_addr] == 0
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  per port: 1 when the addressed register is pending
- busy_vec  out  NREGS  raw scoreboard bits
- iss_err  out  1  sticky; set when iss_en is asserted while iss_ready == 0

## Operation
- Storage: NREGS x DATA_W flops. Scoreboard: NREGS busy bits.
- Write: on clk, if wr_en, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Issue: on clk, if iss_en and iss_ready, busy[iss_addr] <= 1.
- Issue while not ready: scoreboard unchanged, iss_err <= 1. iss_err clears only on reset.
- Issue and write to the same address in the same cycle:
  - Data is written.
  - The iss_ready check uses the pre-edge busy bit.
  - If the issue is accepted, busy ends at 1, because issue wins over the clear.
- Issue and write to different addresses: both take effect independently.
- Reads: combinational and unclocked.
  - rd_data[k] = regs[rd_addr[k]]
  - rd_busy[k] = busy[rd_addr[k]]
- All read ports may address the same register; there are no port conflicts.
- Widths: wr_data is stored unmodified. No sign extension or truncation occurs inside the block.

## Timing
- Reset has priority over all other inputs. On the reset cycle's edge:
  - all regs <= 0
  - busy_vec <= 0
  - iss_err <= 0
- Outputs after reset:
  - rd_data = 0 for every port
  - rd_busy = 0
  - iss_ready = 1
- Reset asserted mid-operation discards every pending busy bit. Later writebacks to those registers are ordinary writes.
- Write-to-read latency is one edge: data written at edge N is visible on rd_data after edge N.
- Busy is set at the edge where the issue is accepted and is visible after that edge.
- Busy is cleared at the writeback edge.
- A writeback to a register that is not busy is legal: data is written and busy stays 0.

## Configuration
- Macro: LC3_REGFILE_BYPASS_EN.
- Defined: same-cycle write forwarding. For each port k, if wr_en && wr_addr == rd_addr[k]:
  - rd_data[k] = wr_data
  - rd_busy[k] = 0
- Defined: iss_ready is unaffected by forwarding. Issue always checks the registered busy bit.
- Undefined: no forwarding. Read ports reflect only the registered state, so a consumer waits one extra cycle after writeback.

## Test plan
- Reset clears state: write 16'hBEEF to R3, then assert reset for one cycle. Required: rd_data = 0 on every port, busy_vec = 0, iss_err = 0, iss_ready = 1.
- Write then read: write R5 = 16'h1234 at edge N, with rd_addr port0 = 5 and port1 = 5. Required: both ports read 16'h1234 after edge N; R0–R4 and R6–R7 unchanged.
- Scoreboard round trip:
  - Issue R2; required after the edge: rd_busy = 1 on any port reading R2, iss_ready = 0 for iss_addr = 2.
  - Write R2 = 16'h00FF; required after the edge: busy[2] = 0 and rd_data = 16'h00FF.
- Double issue: issue R7 twice on consecutive cycles with no writeback. Required: iss_err = 1 after the second edge and stays 1 until reset; busy_vec = 8'h80.
- Same-cycle issue and write: R4 is not busy; assert iss_en with iss_addr = 4 and wr_en with wr_addr = 4, wr_data = 16'hA5A5 in the same cycle. Required: R4 = 16'hA5A5, busy[4] = 1, iss_err = 0.
- Bypass, with LC3_REGFILE_BYPASS_EN defined: wr_en, wr_addr = 1, wr_data = 16'h7777, rd_addr port0 = 1, all in the same cycle. Required before the edge: rd_data port0 = 16'h7777 and rd_busy port0 = 0. Without the macro, the same stimulus must show the old R1 value before the edge.
